arm_mc_controller: RTL and testbench

Multicycle control unit for the ARM core. It decodes `Instr[31:12]`, holds the NZCV condition flags and steps a Moore state machine. That state machine sequences a single shared ALU and a single unified instruction/data memory port over 3–5 cycles per instruction. It replaces the single-cycle controller when the core is built around one memory and one adder. Its enables and selects drive the multicycle datapath directly.

---
 rtl/arm_mc_controller_pkg.sv | 67 ++++++
 rtl/arm_mc_controller_if.sv | 31 +++
 rtl/arm_mc_controller_cond_unit.sv | 56 +++++
 rtl/arm_mc_controller.sv | 132 +++++++++++++
 tb/tb_arm_mc_controller.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/arm_mc_controller_pkg.sv
// Shared types and encodings for the multicycle ARM controller.
// States, ALU codes, op classes and condition codes.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } mc_state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_EOR = 4'b0100;
  localparam logic [3:0] ALU_MOV = 4'b0101;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  function automatic logic [3:0] alu_dec(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD: alu_dec = ALU_ADD;
      CMD_SUB: alu_dec = ALU_SUB;
      CMD_CMP: alu_dec = ALU_SUB;
      CMD_AND: alu_dec = ALU_AND;
      CMD_ORR: alu_dec = ALU_ORR;
      CMD_EOR: alu_dec = ALU_EOR;
      CMD_MOV: alu_dec = ALU_MOV;
      default: alu_dec = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/arm_mc_controller_if.sv
// Controller <-> datapath bundle: decoded instruction and flags in,
// enables and mux selects out.
interface arm_mc_controller_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic        AdrSrc;
  logic [1:0]  ResultSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic [3:0]  ALUControl;

  modport master (
    output Instr, ALUFlags,
    input  PCWrite, IRWrite, RegWrite, MemWrite,
    input  AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
    input  ImmSrc, RegSrc, ALUControl
  );

  modport slave (
    input  Instr, ALUFlags,
    output PCWrite, IRWrite, RegWrite, MemWrite,
    output AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
    output ImmSrc, RegSrc, ALUControl
  );
endinterface

// File: rtl/arm_mc_controller_cond_unit.sv
// NZCV flag register and condition-code evaluation.
// Updates are gated by this instruction's own CondEx (old flags).
module cond_unit
  import arm_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       nz_upd,
  input  logic       cv_upd,
  output logic       cond_ex
);

  logic [3:0] flags_q, flags_d;
  logic n, z, c, v;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    unique case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = n == v;
      COND_LT: cond_ex = n != v;
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (nz_upd && cond_ex)
      flags_d[3:2] = alu_flags[3:2];
    if (cv_upd && cond_ex)
      flags_d[1:0] = alu_flags[1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: Moore FSM sequencing one ALU and one
// unified memory port, with condition-gated write enables.
module arm_mc_controller
  import arm_mc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  arm_mc_controller_if.slave bus
);

  mc_state_t state_q, state_d;

  logic [3:0] cond, cmd;
  logic [1:0] op;
  logic       imm_f, s_bit;

  assign cond  = bus.Instr[19:16];
  assign op    = bus.Instr[15:14];
  assign imm_f = bus.Instr[13];
  assign cmd   = bus.Instr[12:9];
  assign s_bit = bus.Instr[8];

  logic fetch_pc, ir_w, reg_w, mem_w, branch;
  logic adr_src, src_a;
  logic [1:0] res_src, src_b;
  logic [3:0] alu_ctl;
  logic is_exec, nz_upd, cv_upd, cond_ex;

  assign is_exec = (state_q == S_EXECR) || (state_q == S_EXECI);
  assign nz_upd  = is_exec && (s_bit || cmd == CMD_CMP);
  assign cv_upd  = nz_upd &&
    (cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_CMP);

  cond_unit u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (cond),
    .alu_flags (bus.ALUFlags),
    .nz_upd    (nz_upd),
    .cv_upd    (cv_upd),
    .cond_ex   (cond_ex)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = imm_f ? S_EXECI : S_EXECR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = s_bit ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECR:   state_d = S_ALUWB;
      S_EXECI:   state_d = S_ALUWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    fetch_pc = 1'b0;
    ir_w     = 1'b0;
    reg_w    = 1'b0;
    mem_w    = 1'b0;
    branch   = 1'b0;
    adr_src  = 1'b0;
    src_a    = 1'b0;
    res_src  = 2'b00;
    src_b    = 2'b00;
    alu_ctl  = ALU_ADD;
    unique case (state_q)
      S_FETCH: begin
        fetch_pc = 1'b1;
        ir_w     = 1'b1;
        src_a    = 1'b1;
        src_b    = 2'b10;
        res_src  = 2'b10;
      end
      S_DECODE: begin
        src_a   = 1'b1;
        src_b   = 2'b10;
        res_src = 2'b10;
      end
      S_MEMADR:   src_b = 2'b01;
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        res_src = 2'b01;
        reg_w   = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      S_EXECR:    alu_ctl = alu_dec(cmd);
      S_EXECI: begin
        src_b   = 2'b01;
        alu_ctl = alu_dec(cmd);
      end
      S_ALUWB:    reg_w = (cmd != CMD_CMP);
      S_BRANCH: begin
        src_b   = 2'b01;
        res_src = 2'b10;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are held low for the whole reset pulse.
  assign bus.PCWrite  = ~reset & (fetch_pc | (branch & cond_ex));
  assign bus.IRWrite  = ~reset & ir_w;
  assign bus.RegWrite = ~reset & reg_w & cond_ex;
  assign bus.MemWrite = ~reset & mem_w & cond_ex;

  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = res_src;
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ALUControl = alu_ctl;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {op == OP_MEM, op == OP_BR};

endmodule

// File: tb/tb_arm_mc_controller.sv
// Instruction-table bench for arm_mc_controller with a per-cycle
// expected-control scoreboard.
module tb_arm_mc_controller;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  arm_mc_controller_if bus ();

  arm_mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [3:0] L_F   = 4'd0;
  localparam logic [3:0] L_D   = 4'd1;
  localparam logic [3:0] L_MA  = 4'd2;
  localparam logic [3:0] L_MR  = 4'd3;
  localparam logic [3:0] L_MW  = 4'd4;
  localparam logic [3:0] L_MWR = 4'd5;
  localparam logic [3:0] L_ER  = 4'd6;
  localparam logic [3:0] L_EI  = 4'd7;
  localparam logic [3:0] L_AW  = 4'd8;
  localparam logic [3:0] L_BR  = 4'd9;
  localparam logic [3:0] L_RST = 4'd10;

  typedef struct {
    logic [19:0]     ins;
    logic [3:0]      fl;
    logic            ce;
    int              n;
    logic [0:4][3:0] seq;
    string           nm;
  } vec_t;

  vec_t        vecs[$];
  logic [17:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic vec_t mk(
    input logic [19:0] ins, input logic [3:0] fl, input logic ce,
    input int n, input logic [3:0] s0, s1, s2, s3, s4, input string nm);
    vec_t v;
    v.ins = ins; v.fl = fl; v.ce = ce; v.n = n;
    v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2;
    v.seq[3] = s3; v.seq[4] = s4;
    v.nm = nm;
    return v;
  endfunction

  function automatic logic [3:0] ref_alu(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 4'b0000;
      4'b0010, 4'b1010: return 4'b0001;
      4'b0000: return 4'b0010;
      4'b1100: return 4'b0011;
      4'b0001: return 4'b0100;
      4'b1101: return 4'b0101;
      default: return 4'b0000;
    endcase
  endfunction

  // {PCW,IRW,RegW,MemW,AdrSrc,ResSrc,SrcA,SrcB,ImmSrc,RegSrc,ALUCtl}
  function automatic logic [17:0] exp_ctl(
    input logic [3:0] lbl, input logic [19:0] ins, input logic ce);
    logic pcw, irw, rw, mw, adr, sa;
    logic [1:0] rs, sb, op;
    logic [3:0] alu;
    op = ins[15:14];
    {pcw, irw, rw, mw, adr, sa} = '0;
    rs = 2'b00; sb = 2'b00; alu = 4'b0000;
    case (lbl)
      L_F:   begin pcw = 1; irw = 1; sa = 1; sb = 2'b10; rs = 2'b10; end
      L_RST: begin sa = 1; sb = 2'b10; rs = 2'b10; end
      L_D:   begin sa = 1; sb = 2'b10; rs = 2'b10; end
      L_MA:  sb = 2'b01;
      L_MR:  adr = 1;
      L_MW:  begin rs = 2'b01; rw = ce; end
      L_MWR: begin adr = 1; mw = ce; end
      L_ER:  alu = ref_alu(ins[12:9]);
      L_EI:  begin sb = 2'b01; alu = ref_alu(ins[12:9]); end
      L_AW:  rw = ce & (ins[12:9] != 4'b1010);
      L_BR:  begin sb = 2'b01; rs = 2'b10; pcw = ce; end
      default: ;
    endcase
    return {pcw, irw, rw, mw, adr, rs, sa, sb, op,
            op == 2'b01, op == 2'b10, alu};
  endfunction

  task automatic drive_chk(input logic [19:0] ins, input logic [3:0] fl,
                           input logic [3:0] lbl, input logic ce,
                           input string nm);
    logic [17:0] got, e;
    bus.Instr    = ins;
    bus.ALUFlags = fl;
    exp_q.push_back(exp_ctl(lbl, ins, ce));
    #1;
    got = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite,
           bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
           bus.ImmSrc, bus.RegSrc, bus.ALUControl};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s state %0d: got %b expected %b", nm, lbl, got, e);
    end
  endtask

  task automatic step(input logic [19:0] ins, input logic [3:0] fl,
                      input logic [3:0] lbl, input logic ce,
                      input string nm);
    drive_chk(ins, fl, lbl, ce, nm);
    @(negedge clk);
  endtask

  initial begin
    vecs.push_back(mk(20'hE0821, 4'b0000, 1, 4, L_F, L_D, L_ER, L_AW, L_F, "add"));
    vecs.push_back(mk(20'hE0500, 4'b0100, 1, 4, L_F, L_D, L_ER, L_AW, L_F, "subs"));
    vecs.push_back(mk(20'h0A000, 4'b0000, 1, 3, L_F, L_D, L_BR, L_F, L_F, "beq_taken"));
    vecs.push_back(mk(20'h10821, 4'b1111, 0, 4, L_F, L_D, L_ER, L_AW, L_F, "addne_skip"));
    vecs.push_back(mk(20'h0A000, 4'b0000, 1, 3, L_F, L_D, L_BR, L_F, L_F, "beq_still"));
    vecs.push_back(mk(20'hE1500, 4'b0000, 1, 4, L_F, L_D, L_ER, L_AW, L_F, "cmp"));
    vecs.push_back(mk(20'h0A000, 4'b0000, 0, 3, L_F, L_D, L_BR, L_F, L_F, "beq_not"));
    vecs.push_back(mk(20'hE3811, 4'b1111, 1, 4, L_F, L_D, L_EI, L_AW, L_F, "orr_imm"));
    vecs.push_back(mk(20'h0A000, 4'b0000, 0, 3, L_F, L_D, L_BR, L_F, L_F, "beq_after_orr"));
    vecs.push_back(mk(20'hE0900, 4'b0011, 1, 4, L_F, L_D, L_ER, L_AW, L_F, "adds"));
    vecs.push_back(mk(20'hE0100, 4'b1100, 1, 4, L_F, L_D, L_ER, L_AW, L_F, "ands"));
    vecs.push_back(mk(20'h2A000, 4'b0000, 1, 3, L_F, L_D, L_BR, L_F, L_F, "bcs"));
    vecs.push_back(mk(20'h7A000, 4'b0000, 0, 3, L_F, L_D, L_BR, L_F, L_F, "bvc"));
    vecs.push_back(mk(20'hE5821, 4'b0000, 1, 4, L_F, L_D, L_MA, L_MWR, L_F, "str"));
    vecs.push_back(mk(20'hEC000, 4'b0000, 1, 2, L_F, L_D, L_F, L_F, L_F, "nop"));
    vecs.push_back(mk(20'hE5921, 4'b0000, 1, 5, L_F, L_D, L_MA, L_MR, L_MW, "ldr"));

    reset = 1'b1;
    bus.Instr = '0;
    bus.ALUFlags = '0;
    repeat (2) @(negedge clk);
    drive_chk(20'hE0821, 4'b0000, L_RST, 1, "reset_state");
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i])
      for (int c = 0; c < vecs[i].n; c++)
        step(vecs[i].ins, vecs[i].fl, vecs[i].seq[c], vecs[i].ce, vecs[i].nm);

    // LDR abandoned by reset in MEMREAD; flags (1111 here) must clear.
    step(20'hE5921, 4'b0000, L_F, 1, "ldr_rst");
    step(20'hE5921, 4'b0000, L_D, 1, "ldr_rst");
    step(20'hE5921, 4'b0000, L_MA, 1, "ldr_rst");
    drive_chk(20'hE5921, 4'b0000, L_MR, 1, "ldr_rst");
    reset = 1'b1;
    drive_chk(20'hE5921, 4'b0000, L_RST, 1, "mid_reset");
    @(negedge clk);
    drive_chk(20'hE5921, 4'b0000, L_RST, 1, "mid_reset_hold");
    reset = 1'b0;
    drive_chk(20'h0A000, 4'b0000, L_F, 0, "post_reset_fetch");
    @(negedge clk);
    step(20'h0A000, 4'b0000, L_D, 0, "post_reset_beq");
    step(20'h0A000, 4'b0000, L_BR, 0, "post_reset_beq");
    step(20'h0A000, 4'b0000, L_F, 0, "post_reset_next");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
